// File: rtl/dmem_arbiter_if.sv
// Bundles the core MEM-stage, debug/loader and data-memory signals seen by dmem_arbiter.
// slave = arbiter view; master = requesters plus memory (environment) view.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_stall;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, m_rdata,
    output c_rdata, c_stall, d_gnt, d_rvalid, d_rdata, m_we, m_addr, m_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  c_rdata, c_stall, d_gnt, d_rvalid, d_rdata, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core MEM stage and the debug/loader port.
// Define DMEM_ARB_STARVE_EN to force a debug grant after MAX_WAIT losses; otherwise the core has strict priority.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, C_RD, D_RD} state_e;

  state_e        state_q, state_d;
  logic          issue_en;
  logic          in_c_rd;
  logic          in_d_rd;
  logic          dbg_win;
  logic          core_win;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_check
    $error("dmem_arbiter: MAX_WAIT must be in 1..15");
  end

  // Reset low blocks issue and read-data presentation, so only c_stall = c_req remains visible.
  assign issue_en = reset & (state_q == IDLE);
  assign in_c_rd  = reset & (state_q == C_RD);
  assign in_d_rd  = reset & (state_q == D_RD);

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       dbg_lose;

  assign dbg_win  = issue_en & bus.d_req & (~bus.c_req | (wait_cnt_q == MAX_WAIT_C));
  assign dbg_lose = issue_en & bus.d_req & bus.c_req & ~dbg_win;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (dbg_win) begin
      wait_cnt_d = '0;
    end else if (dbg_lose && (wait_cnt_q != MAX_WAIT_C)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end
`else
  assign dbg_win = issue_en & bus.d_req & ~bus.c_req;
`endif

  assign core_win = issue_en & bus.c_req & ~dbg_win;

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    state_d = IDLE;
    if (dbg_win) begin
      m_we    = bus.d_we;
      m_addr  = bus.d_addr;
      m_wdata = bus.d_wdata;
      if (!bus.d_we) state_d = D_RD;
    end else if (core_win) begin
      m_we    = bus.c_we;
      m_addr  = bus.c_addr;
      m_wdata = bus.c_wdata;
      if (!bus.c_we) state_d = C_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
`ifdef DMEM_ARB_STARVE_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
`ifdef DMEM_ARB_STARVE_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign bus.m_we     = m_we;
  assign bus.m_addr   = m_addr;
  assign bus.m_wdata  = m_wdata;
  assign bus.d_gnt    = dbg_win;
  assign bus.d_rvalid = in_d_rd;
  assign bus.d_rdata  = in_d_rd ? bus.m_rdata : '0;
  assign bus.c_rdata  = in_c_rd ? bus.m_rdata : '0;
  assign bus.c_stall  = bus.c_req & ~((core_win & bus.c_we) | in_c_rd);
endmodule
